// File: rtl/cmp_pkg.sv
// Shared constants for the serial magnitude comparator: FSM state encoding
// and bit positions of the one-hot result vector.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } cmp_state_t;

  localparam int RES_LT = 0;
  localparam int RES_EQ = 1;
  localparam int RES_GT = 2;
  localparam int RES_W  = 3;

endpackage

// File: rtl/mag_cmp_cell.sv
// One bit of the MSB-first magnitude compare recurrence: folds a bit pair
// into the running equal/less/greater state.
module mag_cmp_cell (
  input  logic a,
  input  logic b,
  input  logic e_in,
  input  logic l_in,
  input  logic g_in,
  output logic e_out,
  output logic l_out,
  output logic g_out
);

  // Once a higher bit has decided the result, e_in is 0 and l/g are frozen.
  assign l_out = l_in | (e_in & ~a & b);
  assign g_out = g_in | (e_in & a & ~b);
  assign e_out = e_in & ~(a ^ b);

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with one-hot lt/eq/gt result and done pulse.
// Define EARLY_TERM_EN to finish on the first differing bit pair instead of after WIDTH beats.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic a_lt_b,
  output logic a_eq_b,
  output logic a_gt_b
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  cmp_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             e_reg, e_next;
  logic             l_reg, l_next;
  logic             g_reg, g_next;
  logic [RES_W-1:0] res_reg, res_next;

  logic e_cell, l_cell, g_cell;
  logic beat;
  logic last_beat;

  mag_cmp_cell u_cell (
    .a     (a_bit),
    .b     (b_bit),
    .e_in  (e_reg),
    .l_in  (l_reg),
    .g_in  (g_reg),
    .e_out (e_cell),
    .l_out (l_cell),
    .g_out (g_cell)
  );

  assign beat = (state_reg == ST_SHIFT) && bit_valid;

`ifdef EARLY_TERM_EN
  // A mismatch while still equal fixes the outcome; lower bits cannot change it.
  assign last_beat = beat && ((cnt_reg == CNT_LAST) || (e_reg && (a_bit ^ b_bit)));
`else
  assign last_beat = beat && (cnt_reg == CNT_LAST);
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    e_next     = e_reg;
    l_next     = l_reg;
    g_next     = g_reg;
    res_next   = res_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_SHIFT;
          cnt_next   = '0;
          e_next     = 1'b1;
          l_next     = 1'b0;
          g_next     = 1'b0;
          res_next   = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (beat) begin
          e_next = e_cell;
          l_next = l_cell;
          g_next = g_cell;
          // Counter holds on the last beat so it never wraps.
          if (last_beat) begin
            state_next       = ST_DONE;
            res_next[RES_LT] = l_cell;
            res_next[RES_EQ] = e_cell;
            res_next[RES_GT] = g_cell;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      e_reg     <= 1'b1;
      l_reg     <= 1'b0;
      g_reg     <= 1'b0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      e_reg     <= e_next;
      l_reg     <= l_next;
      g_reg     <= g_next;
      res_reg   <= res_next;
    end
  end

  assign busy   = (state_reg == ST_SHIFT);
  assign done   = (state_reg == ST_DONE);
  assign a_lt_b = res_reg[RES_LT];
  assign a_eq_b = res_reg[RES_EQ];
  assign a_gt_b = res_reg[RES_GT];

endmodule
